// File: rtl/arb_buffered_mux_2ch.sv
// Two-channel buffered arbiter/mux: each input feeds a small FIFO, and a round-robin arbiter
// drains both FIFOs into a single registered valid/ready output stage.
module arb_buffered_mux_2ch #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q   [2][DEPTH];
  logic [WIDTH-1:0] mem_d   [2][DEPTH];
  logic [AW-1:0]    wptr_q  [2];
  logic [AW-1:0]    wptr_d  [2];
  logic [AW-1:0]    rptr_q  [2];
  logic [AW-1:0]    rptr_d  [2];
  logic [CW-1:0]    cnt_q   [2];
  logic [CW-1:0]    cnt_d   [2];
  logic [WIDTH-1:0] in_data [2];

  logic             last_src_q, last_src_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_src_q, out_src_d;

  logic [1:0] in_valid, in_ready, push, pop, req;
  logic       load_en, sel;

  assign in_valid   = {in1_valid, in0_valid};
  assign in_data[0] = in0_data;
  assign in_data[1] = in1_data;

  // Ready is gated by rst directly so it drops the moment reset asserts.
  assign in_ready[0] = rst && (cnt_q[0] != FullCnt);
  assign in_ready[1] = rst && (cnt_q[1] != FullCnt);
  assign push        = in_valid & in_ready;

  // Arbitration works from registered occupancy only, never a same-edge push.
  always_comb begin
    req[0]  = (cnt_q[0] != '0);
    req[1]  = (cnt_q[1] != '0);
    load_en = (!out_valid_q || out_ready) && (req != 2'b00);
    sel     = (req == 2'b11) ? ~last_src_q : req[1];
    pop     = 2'b00;
    if (load_en) begin
      pop[sel] = 1'b1;
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      mem_d[c]  = mem_q[c];
      wptr_d[c] = wptr_q[c];
      rptr_d[c] = rptr_q[c];
      if (push[c]) begin
        mem_d[c][wptr_q[c]] = in_data[c];
        wptr_d[c]           = wptr_q[c] + AW'(1);
      end
      if (pop[c]) begin
        rptr_d[c] = rptr_q[c] + AW'(1);
      end
      cnt_d[c] = cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
    end
  end

  always_comb begin
    last_src_d  = last_src_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (load_en) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[sel][rptr_q[sel]];
      out_src_d   = sel;
      last_src_d  = sel;
    end else if (out_ready) begin
      // Word consumed with nothing to replace it; payload and source hold.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        for (int e = 0; e < int'(DEPTH); e++) begin
          mem_q[c][e] <= '0;
        end
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      last_src_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        mem_q[c]  <= mem_d[c];
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
      last_src_q  <= last_src_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign in0_ready = in_ready[0];
  assign in1_ready = in_ready[1];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb_buffered_mux_2ch.sv
// Directed bench for arb_buffered_mux_2ch: per-channel data scoreboards plus an expected
// source-order queue, checked on every output handshake.
module tb_arb_buffered_mux_2ch;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         in0_valid, in0_ready, in1_valid, in1_ready;
  logic [W-1:0] in0_data, in1_data;
  logic         out_valid, out_ready, out_src;
  logic [W-1:0] out_data;

  arb_buffered_mux_2ch #(.WIDTH(W), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0;
  int nchk  = 0;
  int cyc   = 0;
  int hs_cnt, first_hs, last_hs;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  bit           exp_src[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_out();
    bit           s;
    logic [W-1:0] d;
    if (exp_src.size() == 0) begin
      chk("unexpected_out", {31'd0, out_valid}, 32'd0);
    end else begin
      s = exp_src.pop_front();
      chk("out_src", {31'd0, out_src}, {31'd0, s});
      if ((s && q1.size() == 0) || (!s && q0.size() == 0)) begin
        chk("out_data_noexp", {31'd0, out_valid}, 32'd0);
      end else begin
        d = s ? q1.pop_front() : q0.pop_front();
        chk("out_data", {24'd0, out_data}, {24'd0, d});
      end
      if (hs_cnt == 0) first_hs = cyc;
      last_hs = cyc;
      hs_cnt++;
    end
  endtask

  // Called ~1 time unit after a rising edge; samples mid-cycle, then advances one edge.
  task automatic tick();
    #4;
    if (out_valid && out_ready) check_out();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_src.size() > 0; i++) tick();
    chk(tag, exp_src.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    q0.delete();
    q1.delete();
    exp_src.delete();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0;
    in0_data = '0;    in1_data = '0;
    out_ready = 1'b0;
    hs_cnt = 0; first_hs = 0; last_hs = 0;

    // Reset state
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_src", {31'd0, out_src}, 32'd0);
    chk("rst_in0_ready", {31'd0, in0_ready}, 32'd0);
    chk("rst_in1_ready", {31'd0, in1_ready}, 32'd0);
    #10;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in0_ready", {31'd0, in0_ready}, 32'd1);
    chk("rel_in1_ready", {31'd0, in1_ready}, 32'd1);
    chk("rel_out_valid", {31'd0, out_valid}, 32'd0);

    // Single word, latency and hold after drain
    out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 8'hA5;
    q0.push_back(8'hA5); exp_src.push_back(1'b0);
    tick();
    in0_valid = 1'b0;
    chk("lat_not_early", {31'd0, out_valid}, 32'd0);
    tick();
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_data", {24'd0, out_data}, 32'h0000_00A5);
    chk("single_src", {31'd0, out_src}, 32'd0);
    tick();
    chk("single_drop", {31'd0, out_valid}, 32'd0);
    chk("single_hold_data", {24'd0, out_data}, 32'h0000_00A5);
    chk("single_sb_empty", exp_src.size(), 32'd0);

    // Tie from reset: channel 1 first
    do_reset();
    out_ready = 1'b1;
    in0_valid = 1'b1; in0_data = 8'h11;
    in1_valid = 1'b1; in1_data = 8'h22;
    q0.push_back(8'h11); q1.push_back(8'h22);
    exp_src.push_back(1'b1); exp_src.push_back(1'b0);
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    tick();
    chk("tie_first_valid", {31'd0, out_valid}, 32'd1);
    chk("tie_first_src", {31'd0, out_src}, 32'd1);
    chk("tie_first_data", {24'd0, out_data}, 32'h22);
    tick();
    chk("tie_second_valid", {31'd0, out_valid}, 32'd1);
    chk("tie_second_src", {31'd0, out_src}, 32'd0);
    chk("tie_second_data", {24'd0, out_data}, 32'h11);
    tick();
    chk("tie_done_valid", {31'd0, out_valid}, 32'd0);
    chk("tie_sb_empty", exp_src.size(), 32'd0);

    // Backpressure to full, then a 3-cycle output stall
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in0_valid = 1'b1; in0_data = W'(8'h30 + i);
      chk($sformatf("bp_ready_%0d", i), {31'd0, in0_ready}, 32'd1);
      q0.push_back(W'(8'h30 + i));
      tick();
    end
    in0_valid = 1'b0;
    chk("bp_full_ready", {31'd0, in0_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_out_data", {24'd0, out_data}, 32'h30);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        in0_valid = 1'b1; in0_data = 8'hEE;
        in1_valid = 1'b1; in1_data = 8'h77;
        chk("stall_in1_ready", {31'd0, in1_ready}, 32'd1);
        q1.push_back(8'h77);
      end
      tick();
      in0_valid = 1'b0; in1_valid = 1'b0;
      chk($sformatf("stall_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall_data_%0d", i), {24'd0, out_data}, 32'h30);
      chk($sformatf("stall_src_%0d", i), {31'd0, out_src}, 32'd0);
      chk($sformatf("stall_full_%0d", i), {31'd0, in0_ready}, 32'd0);
    end
    // Channel 0 word in the register, then the tie goes to channel 1, then channel 0 drains.
    exp_src.push_back(1'b0); exp_src.push_back(1'b1);
    for (int i = 0; i < 4; i++) exp_src.push_back(1'b0);
    out_ready = 1'b1;
    drain("bp_drained", 20);
    chk("bp_q0_empty", q0.size(), 32'd0);
    chk("bp_q1_empty", q1.size(), 32'd0);
    chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);

    // Sustained traffic on both channels
    do_reset();
    out_ready = 1'b1;
    hs_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      exp_src.push_back(1'b1); exp_src.push_back(1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      in0_valid = 1'b1; in0_data = W'(8'h40 + i);
      in1_valid = 1'b1; in1_data = W'(8'h50 + i);
      q0.push_back(W'(8'h40 + i)); q1.push_back(W'(8'h50 + i));
      tick();
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    drain("sust_drained", 20);
    chk("sust_hs_count", hs_cnt, 32'd8);
    chk("sust_one_per_cycle", last_hs - first_hs, 32'd7);

    // Asynchronous reset between edges with both FIFOs holding words
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in0_valid = 1'b1; in0_data = W'(8'h60 + i);
      in1_valid = 1'b1; in1_data = W'(8'h70 + i);
      tick();
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    chk("pre_arst_valid", {31'd0, out_valid}, 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in0_ready", {31'd0, in0_ready}, 32'd0);
    chk("arst_in1_ready", {31'd0, in1_ready}, 32'd0);
    chk("arst_out_data", {24'd0, out_data}, 32'd0);
    q0.delete(); q1.delete(); exp_src.delete();
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_rel_in0_ready", {31'd0, in0_ready}, 32'd1);
    chk("arst_rel_in1_ready", {31'd0, in1_ready}, 32'd1);
    chk("arst_rel_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("arst_no_stale", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
